mmc_mailbox_arbiter: RTL and testbench
======================================

# mmc_mailbox_arbiter

Shares the system-side port of the MMC mailbox DPRAM between the CPU GPIO register and up to NCLIENTS hardware requesters, for example autonomous status publishers and command pollers. It sits between the CPU GPIO/CSR pair and the mailbox's `GPIO_OUT`/`GPIO_STROBE`/`csr` pins. Every access is serialised into one mailbox strobe. The CPU sees a private shadow CSR, so client traffic never disturbs the address/data readback the CPU expects.

## Interface
- `NCLIENTS`, default 2: number of hardware requesters, 1..8.
- `ADDRESS_WIDTH`, default 11: mailbox address width, at most 21.
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `cpu_gpio_out` input 32: CPU command word.
  - [31] write.
  - [30] clear-overrun.
  - [8+:ADDRESS_WIDTH] address.
  - [7:0] write data.
- `cpu_gpio_strobe` input 1: single-cycle CPU command strobe.
- `cpu_csr` output 32: shadow CSR.
  - [31] overrun, sticky.
  - [30] busy.
  - [8+:ADDRESS_WIDTH] last CPU address.
  - [7:0] last CPU read data.
  - All other bits are 0.
- `client_req` input NCLIENTS: request, held high until done.
- `client_we` input NCLIENTS: per-client write flag.
- `client_addr` input NCLIENTS*ADDRESS_WIDTH: per-client address, packed with client i at [i*ADDRESS_WIDTH+:ADDRESS_WIDTH].
- `client_wdata` input NCLIENTS*8: per-client write data, packed.
- `client_done` output NCLIENTS: one-cycle completion pulse.
- `client_rdata` output 8: read data, shared by all clients, valid while the matching done is high and held afterwards.
- `mbox_gpio_out` output 32: command word to the mailbox.
- `mbox_gpio_strobe` output 1: strobe to the mailbox.
- `mbox_csr` input 32: mailbox CSR. Byte [7:0] is valid one cycle after the strobe.

## Operation
- CPU capture: a `cpu_gpio_strobe` loads `cpu_gpio_out` into a pending register and sets `cpu_pend`.
  - If `cpu_pend` is already set, the new strobe is dropped and `overrun` is set.
  - Accepting a strobe with bit[30]=1 clears `overrun`. The access still executes with bit[30] forced to 0.
- The FSM has three states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If `cpu_pend` is set, select the CPU. The CPU has fixed priority.
  - Otherwise select the first client with `req` high, searching round-robin from `rr_ptr`.
  - On a selection, register `mbox_gpio_out` and move to ISSUE.
  - With no requester, stay in IDLE.
- Command word for a client: {we, 12'b0, addr[ADDRESS_WIDTH-1:0], wdata}, zero-padded so the address sits at [8+:ADDRESS_WIDTH] and bit 31 is the write flag.
- ISSUE: `mbox_gpio_strobe`=1 for exactly this cycle, then move to CAPTURE.
- CAPTURE:
  - Register `mbox_csr[7:0]` into `client_rdata`, or into `cpu_csr[7:0]` for a CPU access. For a CPU access, also update `cpu_csr` address bits from the pending word.
  - A write returns the pre-write data, because the mailbox RAM is read-first.
  - Move to IDLE. The next cycle pulses `client_done[i]`, or clears `cpu_pend` for a CPU access.
- Round-robin: `rr_ptr` moves to (granted index + 1) mod NCLIENTS after each client grant. It is unchanged after CPU accesses.
- A client whose done pulses in a cycle is excluded from selection in that same cycle. Clients must drop `req` on done.
- `busy` = `cpu_pend`. The CPU polls this bit before reading `cpu_csr[7:0]`.
- Client accesses never modify `cpu_csr[29:0]`.

## Timing
- Reset values:
  - All outputs 0.
  - `cpu_csr`=0.
  - `rr_ptr`=0.
  - `cpu_pend`=0.
  - `overrun`=0.
  - FSM in IDLE.
- Reset mid-transaction abandons the access. No done is issued, the strobe is low from the next cycle, and pending CPU commands are lost.
- Client timeline: `req` rises in cycle 0 (FSM in IDLE).
  - Cycle 1: strobe.
  - Cycle 2: capture.
  - Cycle 3: `done` and `rdata` valid.
- CPU timeline: strobe in cycle 0.
  - Cycle 1: pend visible.
  - Cycle 2: mailbox strobe, at the earliest.
  - Cycle 4: busy clears.
- Worst-case CPU latency is 6 cycles from the strobe to `busy`=0, when a client transaction is in flight.
- Throughput: one mailbox access per 3 cycles.
- Sustained CPU priority starves clients. CPU strobes are rate-limited by software polling of busy.
- Never more than one `mbox_gpio_strobe` per 3 cycles.

## Test plan
- CPU write: strobe with 0x8000_0_5A5 (addr 0x05, data 0xA5), then a CPU read of addr 0x05 → `busy` falls 3 cycles after the second strobe is pended; `cpu_csr` = 0x0000_05A5.
- Client 1 read of addr 0x123, mailbox preloaded with 0x3C → `mbox_gpio_out` = 0x0001_2300 with the strobe 1 cycle after `req`; `client_done[1]` 3 cycles after `req`; `client_rdata` = 0x3C; `cpu_csr` unchanged.
- CPU strobe and both client reqs in the same cycle → order is CPU, client 0, client 1; three strobes spaced 3 cycles apart.
- Both clients hold `req` continuously (re-raised after done) for 8 grants → grants alternate 0,1,0,1… with no double grant on the done cycle.
- Two CPU strobes 1 cycle apart → the second is dropped and `cpu_csr[31]`=1. A later strobe with bit30=1 → `cpu_csr[31]`=0.
- `rst` asserted in the CAPTURE cycle of a client access → no `client_done`; all outputs 0 in the following cycle; a fresh request completes normally.

Source files
------------

// File: rtl/mmc_mailbox_arbiter_if.sv
// ---------------------------------------------------------------------------
// mmc_mailbox_arbiter_if
// System-side pins of the MMC mailbox DPRAM.
//   mbox_gpio_out    : command word {write, ..., address, write data}
//   mbox_gpio_strobe : one-cycle access strobe
//   mbox_csr         : mailbox CSR; byte [7:0] holds read data one cycle
//                      after the strobe
// master modport: the arbiter (drives command + strobe).
// slave modport : the mailbox (returns the CSR).
// ---------------------------------------------------------------------------
interface mmc_mailbox_arbiter_if;
    logic [31:0] mbox_gpio_out;
    logic        mbox_gpio_strobe;
    logic [31:0] mbox_csr;

    modport master (
        output mbox_gpio_out,
        output mbox_gpio_strobe,
        input  mbox_csr
    );

    modport slave (
        input  mbox_gpio_out,
        input  mbox_gpio_strobe,
        output mbox_csr
    );
endinterface

// File: rtl/mmc_mailbox_arbiter.sv
// ---------------------------------------------------------------------------
// mmc_mailbox_arbiter
// Serialises CPU GPIO commands and up to NCLIENTS hardware requesters onto
// the single system-side port of the MMC mailbox. The CPU has fixed priority
// and sees a private shadow CSR that client traffic never touches; clients
// are served round-robin. Each access takes IDLE -> ISSUE -> CAPTURE.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   cpu_gpio_out     : CPU command {[31] write, [30] clear-overrun,
//                      [8+:AW] address, [7:0] data}
//   cpu_gpio_strobe  : one-cycle CPU command strobe
//   cpu_csr          : shadow CSR {[31] overrun, [30] busy,
//                      [8+:AW] last CPU address, [7:0] last CPU read data}
//   client_req/we    : per-client request (held until done) and write flag
//   client_addr      : packed per-client addresses
//   client_wdata     : packed per-client write data
//   client_done      : one-cycle completion pulse per client
//   client_rdata     : shared read data, valid with done and held after
//   mbox             : mailbox pins (master side)
// ---------------------------------------------------------------------------
module mmc_mailbox_arbiter #(
    parameter int NCLIENTS      = 2,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       cpu_gpio_out,
    input  logic                              cpu_gpio_strobe,
    output logic [31:0]                       cpu_csr,
    input  logic [NCLIENTS-1:0]               client_req,
    input  logic [NCLIENTS-1:0]               client_we,
    input  logic [NCLIENTS*ADDRESS_WIDTH-1:0] client_addr,
    input  logic [NCLIENTS*8-1:0]             client_wdata,
    output logic [NCLIENTS-1:0]               client_done,
    output logic [7:0]                        client_rdata,
    mmc_mailbox_arbiter_if.master             mbox
);
    localparam int PW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              gpio_out_q, gpio_out_d;
    logic                     strobe_q, strobe_d;
    logic                     sel_cpu_q, sel_cpu_d;
    logic [PW-1:0]            grant_q, grant_d;
    logic [PW-1:0]            rr_q, rr_d;
    logic                     cpu_pend_q, cpu_pend_d;
    logic [31:0]              cpu_word_q, cpu_word_d;
    logic                     overrun_q, overrun_d;
    logic [ADDRESS_WIDTH-1:0] csr_addr_q, csr_addr_d;
    logic [7:0]               csr_data_q, csr_data_d;
    logic [NCLIENTS-1:0]      done_q, done_d;
    logic [7:0]               rdata_q, rdata_d;

    logic [31:0]              client_word [NCLIENTS];
    logic [NCLIENTS-1:0]      client_elig;
    logic                     found;
    logic [PW-1:0]            pick;
    logic                     unused_csr_bits;

    // Only the read-data byte of the mailbox CSR is meaningful here.
    assign unused_csr_bits = ^mbox.mbox_csr[31:8];

    // A client whose done is pulsing still has req high this cycle; it must
    // not be granted a second time.
    assign client_elig = client_req & ~done_q;

    generate
        for (genvar gi = 0; gi < NCLIENTS; gi++) begin : g_client_word
            assign client_word[gi] = {client_we[gi], {(23-ADDRESS_WIDTH){1'b0}},
                                      client_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                                      client_wdata[gi*8 +: 8]};
        end
    endgenerate

    // Round-robin search: first eligible client at or after rr_q.
    always_comb begin
        logic [PW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            idx = {1'b0, rr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NCLIENTS)) begin
                idx = idx - (PW+1)'(NCLIENTS);
            end
            if (!found && client_elig[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gpio_out_d = gpio_out_q;
        strobe_d   = 1'b0;
        sel_cpu_d  = sel_cpu_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cpu_pend_d = cpu_pend_q;
        cpu_word_d = cpu_word_q;
        overrun_d  = overrun_q;
        csr_addr_d = csr_addr_q;
        csr_data_d = csr_data_q;
        done_d     = '0;
        rdata_d    = rdata_q;

        // CPU command capture; a strobe while one is pending is lost.
        if (cpu_gpio_strobe) begin
            if (cpu_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                cpu_pend_d     = 1'b1;
                cpu_word_d     = cpu_gpio_out;
                cpu_word_d[30] = 1'b0;
                if (cpu_gpio_out[30]) begin
                    overrun_d = 1'b0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_pend_q) begin
                    gpio_out_d = cpu_word_q;
                    sel_cpu_d  = 1'b1;
                    strobe_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (found) begin
                    gpio_out_d = client_word[pick];
                    sel_cpu_d  = 1'b0;
                    grant_d    = pick;
                    rr_d       = (pick == PW'(NCLIENTS-1)) ? '0 : pick + 1'b1;
                    strobe_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Mailbox RAM is read-first: writes return the old byte too.
                if (sel_cpu_q) begin
                    csr_data_d = mbox.mbox_csr[7:0];
                    csr_addr_d = cpu_word_q[8 +: ADDRESS_WIDTH];
                    cpu_pend_d = 1'b0;
                end else begin
                    rdata_d          = mbox.mbox_csr[7:0];
                    done_d[grant_q]  = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gpio_out_q <= '0;
            strobe_q   <= 1'b0;
            sel_cpu_q  <= 1'b0;
            grant_q    <= '0;
            rr_q       <= '0;
            cpu_pend_q <= 1'b0;
            cpu_word_q <= '0;
            overrun_q  <= 1'b0;
            csr_addr_q <= '0;
            csr_data_q <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gpio_out_q <= gpio_out_d;
            strobe_q   <= strobe_d;
            sel_cpu_q  <= sel_cpu_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_word_q <= cpu_word_d;
            overrun_q  <= overrun_d;
            csr_addr_q <= csr_addr_d;
            csr_data_q <= csr_data_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        cpu_csr                       = '0;
        cpu_csr[31]                   = overrun_q;
        cpu_csr[30]                   = cpu_pend_q;
        cpu_csr[8 +: ADDRESS_WIDTH]   = csr_addr_q;
        cpu_csr[7:0]                  = csr_data_q;
    end

    assign mbox.mbox_gpio_out    = gpio_out_q;
    assign mbox.mbox_gpio_strobe = strobe_q;
    assign client_done           = done_q;
    assign client_rdata          = rdata_q;

endmodule

// File: tb/tb_mmc_mailbox_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmc_mailbox_arbiter
// Drives directed scenarios followed by randomized CPU/client traffic against
// a read-first mailbox responder. A transaction-level model (access start
// cycle, fixed strobe/completion offsets, byte array memory) predicts every
// output each cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_mmc_mailbox_arbiter;
    localparam int N  = 2;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cpu_gpio_out = '0;
    logic          cpu_gpio_strobe = 1'b0;
    logic [31:0]   cpu_csr;
    logic [N-1:0]  client_req = '0;
    logic [N-1:0]  client_we = '0;
    logic [N*AW-1:0] client_addr = '0;
    logic [N*8-1:0]  client_wdata = '0;
    logic [N-1:0]  client_done;
    logic [7:0]    client_rdata;

    always #5 clk = ~clk;

    mmc_mailbox_arbiter_if mbox_if();

    mmc_mailbox_arbiter #(.NCLIENTS(N), .ADDRESS_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_gpio_out    (cpu_gpio_out),
        .cpu_gpio_strobe (cpu_gpio_strobe),
        .cpu_csr         (cpu_csr),
        .client_req      (client_req),
        .client_we       (client_we),
        .client_addr     (client_addr),
        .client_wdata    (client_wdata),
        .client_done     (client_done),
        .client_rdata    (client_rdata),
        .mbox            (mbox_if)
    );

    // Mailbox responder: read-first RAM, data one cycle after the strobe.
    logic [7:0] r_mem [0:2047];
    logic [7:0] r_rd = 8'h00;
    always @(posedge clk) begin
        if (mbox_if.mbox_gpio_strobe) begin
            r_rd <= r_mem[mbox_if.mbox_gpio_out[8 +: AW]];
            if (mbox_if.mbox_gpio_out[31])
                r_mem[mbox_if.mbox_gpio_out[8 +: AW]] <= mbox_if.mbox_gpio_out[7:0];
        end
    end
    assign mbox_if.mbox_csr = {24'hA5C3E1, r_rd};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]    m_mem [0:2047];
    bit            v_pend = 0, v_ov = 0, v_strobe = 0;
    logic [31:0]   v_word = '0, v_pword = '0;
    logic [N-1:0]  v_done = '0;
    logic [7:0]    v_rdata = '0, v_cdata = '0;
    logic [AW-1:0] v_caddr = '0;
    int            v_rr = 0;
    int            cyc = 0, finish_cyc = 0, owner = 0;
    bit            active = 0;
    logic [7:0]    acc_res = '0;
    logic [AW-1:0] acc_addr = '0;
    bit            chk_en = 0;

    initial begin : compare_and_model
        logic [31:0]   w, e;
        int            idx, c, nrr;
        bit            np, nov, nstr;
        logic [31:0]   npw, nword;
        logic [N-1:0]  nd;
        logic [7:0]    nrd, ncd;
        logic [AW-1:0] nca;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e = '0;
                e[31] = v_ov;
                e[30] = v_pend;
                e[8 +: AW] = v_caddr;
                e[7:0] = v_cdata;
                check("mbox_strobe", {31'b0, mbox_if.mbox_gpio_strobe}, {31'b0, v_strobe});
                check("mbox_gpio_out", mbox_if.mbox_gpio_out, v_word);
                check("client_done", {30'b0, client_done}, {30'b0, v_done});
                check("client_rdata", {24'b0, client_rdata}, {24'b0, v_rdata});
                check("cpu_csr", cpu_csr, e);
            end
            if (rst) begin
                v_pend = 0; v_ov = 0; v_strobe = 0; v_word = '0; v_pword = '0;
                v_done = '0; v_rdata = '0; v_cdata = '0; v_caddr = '0; v_rr = 0;
                active = 0; finish_cyc = cyc + 1;
            end else begin
                np = v_pend; nov = v_ov; npw = v_pword; nstr = 0; nword = v_word;
                nd = '0; nrd = v_rdata; ncd = v_cdata; nca = v_caddr; nrr = v_rr;
                // results of the access in flight appear at its finish cycle
                if (active && cyc + 1 == finish_cyc) begin
                    if (owner < 0) begin
                        np = 0; ncd = acc_res; nca = acc_addr;
                    end else begin
                        nd[owner] = 1'b1; nrd = acc_res;
                    end
                    active = 0;
                end
                if (cpu_gpio_strobe) begin
                    if (v_pend) nov = 1;
                    else begin
                        np  = 1;
                        npw = cpu_gpio_out & 32'hBFFF_FFFF;
                        if (cpu_gpio_out[30]) nov = 0;
                    end
                end
                if (cyc >= finish_cyc) begin
                    idx = -2;
                    w   = '0;
                    if (v_pend) begin
                        idx = -1; w = v_pword;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            c = (v_rr + k) % N;
                            if (idx == -2 && client_req[c] && !v_done[c]) begin
                                idx = c;
                                w = (32'(client_we[c]) << 31) |
                                    (32'(client_addr[c*AW +: AW]) << 8) |
                                    32'(client_wdata[c*8 +: 8]);
                            end
                        end
                    end
                    if (idx != -2) begin
                        nstr = 1; nword = w; owner = idx;
                        acc_addr = w[8 +: AW];
                        acc_res  = m_mem[acc_addr];
                        if (w[31]) m_mem[acc_addr] = w[7:0];
                        finish_cyc = cyc + 3;
                        active = 1;
                        if (idx >= 0) nrr = (idx + 1) % N;
                    end
                end
                v_pend = np; v_ov = nov; v_pword = npw; v_strobe = nstr; v_word = nword;
                v_done = nd; v_rdata = nrd; v_cdata = ncd; v_caddr = nca; v_rr = nrr;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    int           cl_mode = 0;   // 0 manual, 1 random, 2 continuous
    bit [N-1:0]   drop_pend = '0;

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(3) == 0) ? AW'($urandom_range(2047)) : AW'($urandom_range(31));
    endfunction

    task automatic new_req(input int i);
        client_req[i] = 1'b1;
        client_we[i]  = 1'($urandom_range(1));
        client_addr[i*AW +: AW] = rand_addr();
        client_wdata[i*8 +: 8]  = 8'($urandom);
    endtask

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            if (drop_pend[i]) begin
                client_req[i] = 1'b0;
                drop_pend[i]  = 1'b0;
            end
            if (v_done[i]) drop_pend[i] = 1'b1;
            if (!client_req[i] && ((cl_mode == 2) || (cl_mode == 1 && $urandom_range(2) == 0)))
                new_req(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_gpio_strobe = 1'b0;
        drive_clients();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && cpu_csr[30]; k++) tick();
        check("busy_clear", {31'b0, cpu_csr[30]}, 32'd0);
    endtask

    initial begin : stim
        int          sidx, ndone;
        int          sc [3];
        logic [31:0] sw [3];
        logic [N-1:0] prev_done;
        logic [31:0] w;

        for (int i = 0; i < 2048; i++) begin
            r_mem[i] = 8'(i * 37 + 11);
            m_mem[i] = 8'(i * 37 + 11);
        end
        r_mem[11'h123] = 8'h3C;
        m_mem[11'h123] = 8'h3C;

        tick(); tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        check("rst_csr", cpu_csr, 32'd0);
        check("rst_done", {30'b0, client_done}, 32'd0);
        check("rst_gpio_out", mbox_if.mbox_gpio_out, 32'd0);
        check("rst_strobe", {31'b0, mbox_if.mbox_gpio_strobe}, 32'd0);

        // CPU write of 0xA5 to 0x05 returns the old byte 0xC4
        cpu_gpio_out = 32'h8000_05A5; cpu_gpio_strobe = 1'b1;
        tick();
        wait_idle();
        check("cpu_wr_csr", cpu_csr, 32'h0000_05C4);
        // CPU read back
        cpu_gpio_out = 32'h0000_0500; cpu_gpio_strobe = 1'b1;
        tick(); check("cpu_rd_busy_c1", {31'b0, cpu_csr[30]}, 32'd1);
        tick(); check("cpu_rd_strobe_c2", {31'b0, mbox_if.mbox_gpio_strobe}, 32'd1);
                check("cpu_rd_word_c2", mbox_if.mbox_gpio_out, 32'h0000_0500);
        tick(); check("cpu_rd_busy_c3", {31'b0, cpu_csr[30]}, 32'd1);
        tick(); check("cpu_rd_csr_c4", cpu_csr, 32'h0000_05A5);

        // client 1 read of 0x123
        client_we[1] = 1'b0; client_addr[AW +: AW] = 11'h123; client_req[1] = 1'b1;
        tick(); check("cl1_strobe", {31'b0, mbox_if.mbox_gpio_strobe}, 32'd1);
                check("cl1_word", mbox_if.mbox_gpio_out, 32'h0001_2300);
        tick(); check("cl1_done_c2", {30'b0, client_done}, 32'd0);
        tick(); check("cl1_done_c3", {30'b0, client_done}, 32'd2);
                check("cl1_rdata", {24'b0, client_rdata}, 32'h3C);
                check("cl1_cpu_csr", cpu_csr, 32'h0000_05A5);
        tick(); tick();

        // CPU pending together with both client requests
        cpu_gpio_out = 32'h0000_0500; cpu_gpio_strobe = 1'b1;
        sidx = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) begin
                client_we[0] = 1'b0; client_addr[0 +: AW] = 11'h010; client_wdata[0 +: 8] = 8'h00;
                client_we[1] = 1'b1; client_addr[AW +: AW] = 11'h020; client_wdata[8 +: 8] = 8'h77;
                client_req = 2'b11;
            end
            if (mbox_if.mbox_gpio_strobe) begin
                if (sidx < 3) begin
                    sc[sidx] = t; sw[sidx] = mbox_if.mbox_gpio_out;
                end
                sidx++;
            end
        end
        check("prio_nstrobes", 32'(sidx), 32'd3);
        check("prio_t0", 32'(sc[0]), 32'd2);
        check("prio_t1", 32'(sc[1]), 32'd5);
        check("prio_t2", 32'(sc[2]), 32'd8);
        check("prio_w0", sw[0], 32'h0000_0500);
        check("prio_w1", sw[1], 32'h0000_1000);
        check("prio_w2", sw[2], 32'h8000_2077);

        // both clients continuously requesting: grants alternate
        cl_mode = 2;
        ndone = 0; prev_done = '0;
        for (int t = 0; t < 60 && ndone < 8; t++) begin
            tick();
            if (client_done != '0) begin
                if (ndone > 0)
                    check("alt_grant", {30'b0, client_done}, {30'b0, ~prev_done});
                prev_done = client_done;
                ndone++;
            end
        end
        check("alt_count", 32'(ndone), 32'd8);
        cl_mode = 0;
        for (int t = 0; t < 20 && client_req != '0; t++) tick();
        tick(); tick();

        // overrun: second strobe one cycle later is dropped
        cpu_gpio_out = 32'h0000_0500; cpu_gpio_strobe = 1'b1;
        tick();
        cpu_gpio_out = 32'h0000_0600; cpu_gpio_strobe = 1'b1;
        tick();
        wait_idle();
        check("ovr_set", {31'b0, cpu_csr[31]}, 32'd1);
        check("ovr_addr", {21'b0, cpu_csr[18:8]}, 32'h005);
        cpu_gpio_out = 32'h4000_0500; cpu_gpio_strobe = 1'b1;
        tick(); check("ovr_clr", {31'b0, cpu_csr[31]}, 32'd0);
        wait_idle();
        check("ovr_clr_hold", {31'b0, cpu_csr[31]}, 32'd0);

        // reset during the capture cycle of a client access
        client_we[1] = 1'b0; client_addr[AW +: AW] = 11'h040; client_req[1] = 1'b1;
        tick();
        tick();
        rst = 1'b1; client_req = '0; drop_pend = '0;
        tick();
        rst = 1'b0;
        check("mrst_done", {30'b0, client_done}, 32'd0);
        check("mrst_strobe", {31'b0, mbox_if.mbox_gpio_strobe}, 32'd0);
        check("mrst_word", mbox_if.mbox_gpio_out, 32'd0);
        check("mrst_rdata", {24'b0, client_rdata}, 32'd0);
        check("mrst_csr", cpu_csr, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); check("mrst_no_done", {30'b0, client_done}, 32'd0);
        end
        client_addr[AW +: AW] = 11'h123; client_req[1] = 1'b1;
        tick(); tick(); tick();
        check("mrst_fresh_done", {30'b0, client_done}, 32'd2);
        check("mrst_fresh_rdata", {24'b0, client_rdata}, 32'h3C);
        tick(); tick();

        // randomized traffic
        cl_mode = 1;
        for (int t = 0; t < 4000; t++) begin
            tick();
            rst = 1'b0;
            if ((!v_pend && $urandom_range(5) == 0) || $urandom_range(40) == 0) begin
                w = '0;
                w[31] = 1'($urandom_range(1));
                w[30] = ($urandom_range(3) == 0);
                w[8 +: AW] = rand_addr();
                w[7:0] = 8'($urandom);
                cpu_gpio_out = w;
                cpu_gpio_strobe = 1'b1;
            end
            if ($urandom_range(600) == 0) begin
                rst = 1'b1; client_req = '0; drop_pend = '0;
            end
        end
        cl_mode = 0;
        rst = 1'b0;
        for (int t = 0; t < 30; t++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
